// File: rtl/pulse_period_checker.sv
// rtl/pulse_period_checker.sv - measures spacing of one-cycle ticks, flags early/late/missing ticks, tracks lock
// Optional PULSE_CHECK_SYNC_EN: adds a 2-flop input synchronizer ahead of edge detection.
module pulse_period_checker #(
  parameter int CLK_PERIOD = 5,
  parameter int TIMER_VAL  = 1000,
  parameter int TOL        = 2,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pulse_in,
  input  logic                 clear,
  output logic [CNT_WIDTH-1:0] period_out,
  output logic                 period_valid,
  output logic                 early_err,
  output logic                 late_err,
  output logic                 locked,
  output logic [7:0]           err_count
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_WIDTH-1:0] EXP_C = CNT_WIDTH'(TIMER_VAL / CLK_PERIOD + 1);
  localparam logic [CNT_WIDTH-1:0] LO_C  = EXP_C - CNT_WIDTH'(TOL);
  localparam logic [CNT_WIDTH-1:0] HI_C  = EXP_C + CNT_WIDTH'(TOL);
  localparam logic [GW-1:0]        LOCK_C = GW'(LOCK_COUNT);

  typedef enum logic {IDLE, TRACK} state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [GW-1:0]        good_run_q, good_run_d;
  logic                 pulse_prev_q;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic                 period_valid_q, period_valid_d;
  logic                 early_q, early_d;
  logic                 late_q, late_d;
  logic                 locked_q, locked_d;
  logic [7:0]           err_count_q, err_count_d;
  logic                 pulse_s;
  logic                 ev;
  logic [CNT_WIDTH-1:0] n;

`ifdef PULSE_CHECK_SYNC_EN
  logic sync1_q, sync2_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pulse_in;
      sync2_q <= sync1_q;
    end
  end
  assign pulse_s = sync2_q;
`else
  assign pulse_s = pulse_in;
`endif

  assign ev = pulse_s & ~pulse_prev_q;
  // n is the distance from the last event to the current cycle
  assign n  = cnt_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    good_run_d     = good_run_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    early_d        = 1'b0;
    late_d         = 1'b0;
    locked_d       = locked_q;
    err_count_d    = err_count_q;
    if (clear) begin
      state_d    = IDLE;
      cnt_d      = '0;
      good_run_d = '0;
      locked_d   = 1'b0;
      err_count_d = 8'd0;
    end else if (state_q == IDLE) begin
      cnt_d = '0;
      if (ev) state_d = TRACK;
    end else begin
      cnt_d = n;
      if (ev) begin
        cnt_d          = '0;
        period_d       = n;
        period_valid_d = 1'b1;
        if (n < LO_C) begin
          early_d    = 1'b1;
          good_run_d = '0;
          locked_d   = 1'b0;
        end else if (n > HI_C) begin
          late_d     = 1'b1;
          good_run_d = '0;
          locked_d   = 1'b0;
        end else begin
          if (good_run_q < LOCK_C) good_run_d = good_run_q + 1'b1;
          if (good_run_d == LOCK_C) locked_d = 1'b1;
        end
      end else if (n > HI_C) begin
        // missing tick: report once and wait for the stream to re-arm
        late_d     = 1'b1;
        good_run_d = '0;
        locked_d   = 1'b0;
        state_d    = IDLE;
        cnt_d      = '0;
      end
    end
    if ((early_d || late_d) && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      good_run_q     <= '0;
      pulse_prev_q   <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      early_q        <= 1'b0;
      late_q         <= 1'b0;
      locked_q       <= 1'b0;
      err_count_q    <= 8'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      good_run_q     <= good_run_d;
      pulse_prev_q   <= pulse_s;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      early_q        <= early_d;
      late_q         <= late_d;
      locked_q       <= locked_d;
      err_count_q    <= err_count_d;
    end
  end

  assign period_out   = period_q;
  assign period_valid = period_valid_q;
  assign early_err    = early_q;
  assign late_err     = late_q;
  assign locked       = locked_q;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_pulse_period_checker.sv
// tb/tb_pulse_period_checker.sv - randomized tick streams checked against a timestamp-based model
module tb_pulse_period_checker;
  localparam int CW  = 16;
  localparam int EXP = 1000 / 5 + 1;
  localparam int TOL = 2;
  localparam int LC  = 4;
  localparam int LO  = EXP - TOL;
  localparam int HI  = EXP + TOL;
`ifdef PULSE_CHECK_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pulse_in = 1'b0;
  logic          clear = 1'b0;
  logic [CW-1:0] period_out;
  logic          period_valid;
  logic          early_err;
  logic          late_err;
  logic          locked;
  logic [7:0]    err_count;

  int checks = 0;
  int errors = 0;

  pulse_period_checker #(
    .CLK_PERIOD(5), .TIMER_VAL(1000), .TOL(TOL), .LOCK_COUNT(LC), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .pulse_in(pulse_in), .clear(clear),
    .period_out(period_out), .period_valid(period_valid), .early_err(early_err),
    .late_err(late_err), .locked(locked), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // reference model: stream state kept as event timestamps
  bit m_track, m_prev, m_dl0, m_dl1;
  bit m_pv, m_ee, m_le, m_lock;
  int m_now, m_last, m_good, m_period, m_errc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_track = 0; m_prev = 0; m_dl0 = 0; m_dl1 = 0;
    m_pv = 0; m_ee = 0; m_le = 0; m_lock = 0;
    m_now = 0; m_last = 0; m_good = 0; m_period = 0; m_errc = 0;
  endtask

  task automatic model(input bit p, input bit c);
    bit pe, ev;
    int gap;
    if (LAT == 2) begin
      pe = m_dl1; m_dl1 = m_dl0; m_dl0 = p;
    end else begin
      pe = p;
    end
    ev = pe && !m_prev;
    m_prev = pe;
    m_pv = 0; m_ee = 0; m_le = 0;
    if (c) begin
      m_track = 0; m_good = 0; m_lock = 0; m_errc = 0;
    end else if (!m_track) begin
      if (ev) begin m_track = 1; m_last = m_now; end
    end else begin
      gap = m_now - m_last;
      if (ev) begin
        m_period = gap; m_pv = 1; m_last = m_now;
        if (gap < LO) begin m_ee = 1; m_good = 0; m_lock = 0; end
        else if (gap > HI) begin m_le = 1; m_good = 0; m_lock = 0; end
        else begin
          m_good = (m_good + 1 > LC) ? LC : m_good + 1;
          if (m_good == LC) m_lock = 1;
        end
      end else if (gap == HI + 1) begin
        m_le = 1; m_good = 0; m_lock = 0; m_track = 0;
      end
    end
    if ((m_ee || m_le) && m_errc < 255) m_errc++;
    m_now++;
  endtask

  task automatic check_outputs();
    check("period_out",   32'(period_out),   32'(m_period));
    check("period_valid", 32'(period_valid), 32'(m_pv));
    check("early_err",    32'(early_err),    32'(m_ee));
    check("late_err",     32'(late_err),     32'(m_le));
    check("locked",       32'(locked),       32'(m_lock));
    check("err_count",    32'(err_count),    32'(m_errc));
  endtask

  task automatic step(input bit p, input bit c);
    pulse_in = p;
    clear = c;
    @(negedge clk);
    check_outputs();
    model(p, c);
    @(posedge clk);
    #1;
  endtask

  task automatic send_tick(input int gap, input int width, input bit clr);
    for (int i = 0; i < gap; i++) step(i < width, clr && i == 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic reset_mid();
    pulse_in = 1'b0;
    clear = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_period_out",   32'(period_out),   32'd0);
    check("rst_period_valid", 32'(period_valid), 32'd0);
    check("rst_early_err",    32'(early_err),    32'd0);
    check("rst_late_err",     32'(late_err),     32'd0);
    check("rst_locked",       32'(locked),       32'd0);
    check("rst_err_count",    32'(err_count),    32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int gap, width, r;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    repeat (6) send_tick(EXP, 1, 1'b0);
    send_tick(198, 1, 1'b0);
    send_tick(199, 1, 1'b0);
    repeat (5) send_tick(EXP, 2, 1'b0);
    send_tick(203, 1, 1'b0);
    send_tick(204, 1, 1'b0);
    send_tick(EXP, 1, 1'b0);
    send_tick(EXP, 1, 1'b0);
    idle(300);
    repeat (6) send_tick(EXP, 1, 1'b0);
    send_tick(EXP, 1, 1'b1);
    send_tick(EXP, 1, 1'b0);
    send_tick(EXP, 1, 1'b0);

    repeat (6) send_tick(EXP, 1, 1'b0);
    step(1'b1, 1'b0);
    idle(99);
    reset_mid();
    repeat (3) send_tick(EXP, 1, 1'b0);

    for (int k = 0; k < 60; k++) begin
      r = int'($urandom_range(0, 9));
      if (r < 5)       gap = EXP - 2 + int'($urandom_range(0, 4));
      else if (r < 7)  gap = EXP - 5 + int'($urandom_range(0, 10));
      else if (r == 7) gap = 250;
      else if (r == 8) gap = 30 + int'($urandom_range(0, 20));
      else             gap = EXP;
      width = int'($urandom_range(1, 3));
      send_tick(gap, width, $urandom_range(0, 19) == 0);
    end

    repeat (280) send_tick(12, 1, 1'b0);
    idle(210);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pulse_period_checker.md
Name: pulse_period_checker

Overview:
Receive-side checker for periodic one-cycle tick streams, such as those a pulse generator with the same CLK_PERIOD/TIMER_VAL parameters produces. It measures the cycle distance between consecutive ticks and flags ticks that arrive early, arrive late or go missing. It declares lock after a run of in-tolerance intervals and keeps a saturating error count. It sits beside any timer-driven block whose heartbeat needs supervision.

Parameters:
CLK_PERIOD, 5, clock period in the same units as TIMER_VAL
TIMER_VAL, 1000, nominal tick spacing; EXP = TIMER_VAL/CLK_PERIOD + 1 cycles (integer division)
TOL, 2, allowed deviation from EXP, in cycles
LOCK_COUNT, 4, consecutive good intervals required to assert locked
CNT_WIDTH, 16, width of the interval counter and period_out; EXP+TOL+1 must be < 2^CNT_WIDTH

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-high reset
pulse_in  in  1  tick input, synchronous to clk
clear  in  1  synchronous: return to IDLE, clear locked and err_count
period_out  out  CNT_WIDTH  last measured interval in cycles
period_valid  out  1  one-cycle strobe; period_out updated
early_err  out  1  one-cycle strobe; interval < EXP-TOL
late_err  out  1  one-cycle strobe; interval > EXP+TOL or tick missing
locked  out  1  LOCK_COUNT consecutive good intervals seen
err_count  out  8  saturating count of early_err and late_err strobes

Behaviour:
- Reset (async): all outputs 0, state IDLE, internal counters 0, pulse_in edge register 0.
- Event: pulse_in high while the previous sampled value was low (rising edge). A pulse held high counts once.
- Interval counter cnt: set to 0 on an event cycle, otherwise increments. N = cnt+1 gives the cycle distance between event cycles (events at t and t+N measure N).
- All outputs are registered. Responses appear on the cycle after the deciding cycle.
- IDLE: an event moves to TRACK and starts cnt. No period_valid, no error.
- TRACK, event with N in [EXP-TOL, EXP+TOL]:
  - period_out=N, period_valid=1.
  - good_run increments, saturating at LOCK_COUNT.
  - locked=1 once good_run reaches LOCK_COUNT, in the same cycle as that period_valid.
- TRACK, event with N < EXP-TOL: period_out=N, period_valid=1, early_err=1, good_run=0, locked=0. Stay in TRACK.
- TRACK, cycle where N = EXP+TOL+1:
  - With an event: period_out=N, period_valid=1, late_err=1, good_run=0, locked=0. Stay in TRACK.
  - Without an event (timeout): late_err=1, period_valid=0, good_run=0, locked=0. Go to IDLE.
  - cnt therefore never exceeds EXP+TOL. Exactly one late_err is raised per late or missing tick.
- err_count increments by 1 on each early_err or late_err strobe and saturates at 255.
- clear has priority over everything. An event in the same cycle as clear is ignored. After clear: IDLE, locked=0, err_count=0, good_run=0, period_out held.
- Reset mid-operation: immediate return to reset values. The next event is treated as the first (IDLE).

Optional Feature:
PULSE_CHECK_SYNC_EN:
- Defined: pulse_in passes through a 2-flop synchronizer (reset to 0) before edge detection. This adds exactly 2 cycles of latency to every response. Measured intervals are unchanged.
- Undefined: pulse_in is sampled directly; latencies are as stated above.

Test Plan:
Defaults give EXP=201, TOL=2, LOCK_COUNT=4.
1. Six ticks spaced 201 cycles -> no strobe after tick 1; period_valid with period_out=201 after ticks 2-6; locked rises with the 4th period_valid (after tick 5); err_count=0.
2. Locked stream, then next tick at spacing 198 -> period_out=198, early_err=1, locked=0, err_count=1. Spacing 199 -> no error, good_run restarts.
3. Locked stream, then ticks stop -> late_err exactly one cycle after the cycle at offset 204 from the last tick; period_valid=0; locked=0; next tick gives no period_valid (IDLE re-arm).
4. Spacing 203 -> valid, no error. Spacing 204 delivered as a tick -> period_out=204, late_err=1, state stays TRACK, so the following 201 spacing is measured normally.
5. clear asserted in the same cycle as a tick while locked -> locked=0, err_count=0, no period_valid; the next tick produces no period_valid.
6. Async reset asserted mid-interval (cnt≈100) -> outputs 0 immediately without a clock edge. After release, the first tick only arms, and the second tick at 201 gives a valid measurement. Repeat tests 1 and 3 with PULSE_CHECK_SYNC_EN and check the +2-cycle shift.
